// File: rtl/host_cmd_deframer.sv
// host_cmd_deframer: parses SYNC/CMD/LEN/payload/CHK frames from a host RX FIFO.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   rx_empty, rx_rd_en   - upstream FIFO status / pop request
//   rx_dout              - FIFO data, valid the cycle after rx_rd_en
//   cmd, cmd_valid       - frame opcode and one-cycle update pulse
//   pl_data, pl_valid,
//   pl_ready, pl_last    - payload byte stream, valid/ready handshake
//   frm_ok, frm_err      - one-cycle checksum result pulses
//   err_count            - saturating count of frm_err pulses
module host_cmd_deframer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_empty,
    output logic       rx_rd_en,
    input  logic [7:0] rx_dout,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    input  logic       pl_ready,
    output logic       pl_last,
    output logic       frm_ok,
    output logic       frm_err,
    output logic [7:0] err_count
);

    localparam logic [7:0] SYNC = 8'h5A;

    typedef enum logic [2:0] {
        S_HUNT,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHK
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       byte_pend;
    logic [7:0] chk;
    logic [7:0] cnt;

    // One pop in flight at a time; a pending payload byte blocks further reads.
    assign rx_rd_en = rst_n && !rx_empty && !byte_pend && !pl_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (byte_pend) begin
            unique case (state)
                S_HUNT:    if (rx_dout == SYNC) state_nxt = S_CMD;
                S_CMD:     state_nxt = S_LEN;
                S_LEN:     state_nxt = (rx_dout == 8'h00) ? S_CHK : S_PAYLOAD;
                S_PAYLOAD: if (cnt == 8'h01) state_nxt = S_CHK;
                S_CHK:     state_nxt = S_HUNT;
                default:   state_nxt = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_pend <= 1'b0;
            cmd       <= 8'h00;
            cmd_valid <= 1'b0;
            pl_data   <= 8'h00;
            pl_valid  <= 1'b0;
            pl_last   <= 1'b0;
            frm_ok    <= 1'b0;
            frm_err   <= 1'b0;
            err_count <= 8'h00;
            chk       <= 8'h00;
            cnt       <= 8'h00;
        end else begin
            byte_pend <= rx_rd_en;
            cmd_valid <= 1'b0;
            frm_ok    <= 1'b0;
            frm_err   <= 1'b0;
            if (pl_valid && pl_ready) begin
                pl_valid <= 1'b0;
                pl_last  <= 1'b0;
            end
            if (byte_pend) begin
                unique case (state)
                    S_CMD: begin
                        cmd       <= rx_dout;
                        cmd_valid <= 1'b1;
                        chk       <= rx_dout;
                    end
                    S_LEN: begin
                        cnt <= rx_dout;
                        chk <= chk ^ rx_dout;
                    end
                    S_PAYLOAD: begin
                        pl_data  <= rx_dout;
                        pl_valid <= 1'b1;
                        pl_last  <= (cnt == 8'h01);
                        chk      <= chk ^ rx_dout;
                        cnt      <= cnt - 8'h01;
                    end
                    S_CHK: begin
                        if (rx_dout == chk) begin
                            frm_ok <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                            if (err_count != 8'hFF) err_count <= err_count + 8'h01;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_host_cmd_deframer.sv
// tb_host_cmd_deframer: scoreboard bench for host_cmd_deframer.
// Stimulus pushes bytes and expected events; a negedge monitor checks them.
module tb_host_cmd_deframer;

    localparam logic [1:0] K_CMD = 2'd0;
    localparam logic [1:0] K_PL  = 2'd1;
    localparam logic [1:0] K_OK  = 2'd2;
    localparam logic [1:0] K_ERR = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
        logic       last;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_empty = 1'b1;
    logic       rx_rd_en;
    logic [7:0] rx_dout = 8'h00;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready = 1'b1;
    logic       pl_last;
    logic       frm_ok;
    logic       frm_err;
    logic [7:0] err_count;

    logic [7:0] fifo[$];
    ev_t        exp_q[$];
    bit         rnd_mode = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    bit         hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic       hold_l = 1'b0;

    host_cmd_deframer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_empty  (rx_empty),
        .rx_rd_en  (rx_rd_en),
        .rx_dout   (rx_dout),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_last   (pl_last),
        .frm_ok    (frm_ok),
        .frm_err   (frm_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: data appears the cycle after a pop.
    initial begin
        forever begin
            @(posedge clk);
            if (rx_rd_en && fifo.size() > 0) rx_dout <= fifo.pop_front();
            rx_empty <= (fifo.size() == 0) ||
                        (rnd_mode && ($urandom_range(0, 1) == 1));
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [7:0] d, input logic l);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %02h last %0b, expected none",
                     k, d, l);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.data !== d || e.last !== l) begin
                n_fail++;
                $display("FAIL event: got kind %0d data %02h last %0b, expected kind %0d data %02h last %0b",
                         k, d, l, e.kind, e.data, e.last);
            end
        end
    endtask

    // Monitor: compare every presented output against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cmd_valid) expect_ev(K_CMD, cmd, 1'b0);
                if (pl_valid && pl_ready) expect_ev(K_PL, pl_data, pl_last);
                if (frm_ok) expect_ev(K_OK, 8'h00, 1'b0);
                if (frm_err) expect_ev(K_ERR, 8'h00, 1'b0);
                if (frm_ok && frm_err) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ok_err_overlap: got both high, expected exclusive");
                end
                if (cmd_valid && (frm_ok || frm_err)) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL cmd_frm_overlap: got both high, expected exclusive");
                end
                if (hold_v) begin
                    check("hold_valid", {7'd0, pl_valid}, 8'h01);
                    check("hold_data", pl_data, hold_d);
                    check("hold_last", {7'd0, pl_last}, {7'd0, hold_l});
                end
                if (rx_rd_en) check("rd_while_empty", {7'd0, rx_empty}, 8'h00);
                if (pl_valid) check("rd_while_pl_valid", {7'd0, rx_rd_en}, 8'h00);
                hold_v = pl_valid && !pl_ready;
                hold_d = pl_data;
                hold_l = pl_last;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic send_frame(input logic [7:0] c, input int n,
                              input logic [7:0] p0, input logic [7:0] p1,
                              input bit bad);
        logic [7:0] p[2];
        logic [7:0] x;
        p[0] = p0;
        p[1] = p1;
        x = c ^ n[7:0];
        fifo.push_back(8'h5A);
        fifo.push_back(c);
        fifo.push_back(n[7:0]);
        exp_q.push_back('{K_CMD, c, 1'b0});
        for (int i = 0; i < n; i++) begin
            fifo.push_back(p[i]);
            x = x ^ p[i];
            exp_q.push_back('{K_PL, p[i], (i == n - 1)});
        end
        fifo.push_back(bad ? (x ^ 8'h01) : x);
        exp_q.push_back(bad ? '{K_ERR, 8'h00, 1'b0} : '{K_OK, 8'h00, 1'b0});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0 || fifo.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d events/%0d bytes left, expected 0/0",
                     name, exp_q.size(), fifo.size());
            exp_q.delete();
            fifo.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd"}, cmd, 8'h00);
        check({tag, "_cmd_valid"}, {7'd0, cmd_valid}, 8'h00);
        check({tag, "_pl_data"}, pl_data, 8'h00);
        check({tag, "_pl_valid"}, {7'd0, pl_valid}, 8'h00);
        check({tag, "_pl_last"}, {7'd0, pl_last}, 8'h00);
        check({tag, "_frm_ok"}, {7'd0, frm_ok}, 8'h00);
        check({tag, "_frm_err"}, {7'd0, frm_err}, 8'h00);
        check({tag, "_err_count"}, err_count, 8'h00);
        check({tag, "_rx_rd_en"}, {7'd0, rx_rd_en}, 8'h00);
    endtask

    initial begin
        int n;
        #1;
        check_reset_state("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic frame, two payload bytes.
        send_frame(8'h01, 2, 8'h10, 8'h20, 1'b0);
        drain("basic");
        check("basic_err_count", err_count, 8'h00);

        // Garbage before sync, zero-length payload.
        fifo.push_back(8'h00);
        fifo.push_back(8'hFF);
        send_frame(8'h07, 0, 8'h00, 8'h00, 1'b0);
        drain("hunt");

        // Sync value inside CMD and payload is plain data.
        send_frame(8'h5A, 1, 8'h5A, 8'h00, 1'b0);
        drain("sync_data");

        // Downstream stall for 10 cycles on the first payload byte.
        pl_ready = 1'b0;
        send_frame(8'h01, 2, 8'h10, 8'h20, 1'b0);
        n = 0;
        while (!pl_valid && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("stall_seen", {7'd0, pl_valid}, 8'h01);
        repeat (10) @(posedge clk);
        #1;
        check("stall_pl_data", pl_data, 8'h10);
        check("stall_rd_en", {7'd0, rx_rd_en}, 8'h00);
        pl_ready = 1'b1;
        drain("stall");

        // Random upstream emptiness.
        rnd_mode = 1'b1;
        send_frame(8'h01, 2, 8'h10, 8'h20, 1'b0);
        drain("rand_empty");
        rnd_mode = 1'b0;

        // Bad checksum, then saturate the error counter.
        send_frame(8'h01, 2, 8'h10, 8'h20, 1'b1);
        drain("bad_chk");
        check("err_count_one", err_count, 8'h01);
        for (int i = 0; i < 256; i++) send_frame(8'h01, 2, 8'h10, 8'h20, 1'b1);
        drain("saturate");
        check("err_count_sat", err_count, 8'hFF);

        // Reset in the middle of a frame.
        fifo.push_back(8'h5A);
        fifo.push_back(8'h01);
        fifo.push_back(8'h02);
        fifo.push_back(8'h10);
        exp_q.push_back('{K_CMD, 8'h01, 1'b0});
        exp_q.push_back('{K_PL, 8'h10, 1'b0});
        drain("partial");
        rst_n = 1'b0;
        #1;
        check_reset_state("mid");
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(8'h09, 0, 8'h00, 8'h00, 1'b0);
        drain("post_reset");
        check("post_reset_err_count", err_count, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
